// File: rtl/l1d_evict_wb_buf_pkg.sv
// Shared L1D geometry, evict request / write-back payload layouts and the
// per-buffer lifecycle states used by the evict write-back buffer.
package l1d_evict_wb_buf_pkg;

  localparam int L1D_TAG_WIDTH       = 20;
  localparam int L1D_INDEX_WIDTH     = 6;
  localparam int L1D_OFFSET_WIDTH    = 2;
  localparam int L1D_WAY_WIDTH       = 2;
  localparam int L1D_DATA_WIDTH      = 64;
  localparam int L1D_LINE_BEATS      = 1 << L1D_OFFSET_WIDTH;
  localparam int L1D_EVICT_BUF_DEPTH = 2;

  typedef struct packed {
    logic [L1D_TAG_WIDTH-1:0]    tag;
    logic [L1D_WAY_WIDTH-1:0]    way;
    logic [L1D_INDEX_WIDTH-1:0]  index;
    logic [L1D_OFFSET_WIDTH-1:0] offset;
    logic                        rd_last;
  } pack_l1d_mshr_evict_req_pld;

  typedef struct packed {
    logic [L1D_TAG_WIDTH-1:0]    tag;
    logic [L1D_INDEX_WIDTH-1:0]  index;
    logic [L1D_OFFSET_WIDTH-1:0] offset;
    logic [L1D_DATA_WIDTH-1:0]   data;
    logic                        last;
  } pack_l1d_evict_wb_pld;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } l1d_evict_buf_state_t;

endpackage

// File: rtl/l1d_evict_wb_buf_line_entry.sv
// One victim line buffer: lifecycle state, header captured on allocation,
// and a beat array with one write port and one read mux.
module l1d_evict_line_entry
  import l1d_evict_wb_buf_pkg::*;
#(
  parameter int DATA_WIDTH = L1D_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_alloc,
  input  logic [L1D_TAG_WIDTH-1:0]    i_tag,
  input  logic [L1D_INDEX_WIDTH-1:0]  i_index,
  input  logic [L1D_WAY_WIDTH-1:0]    i_way,
  input  logic [L1D_OFFSET_WIDTH-1:0] i_start_off,
  input  logic                        i_wr_en,
  input  logic [L1D_OFFSET_WIDTH-1:0] i_wr_slot,
  input  logic [DATA_WIDTH-1:0]       i_wr_data,
  input  logic                        i_wr_done,
  input  logic                        i_free,
  input  logic [L1D_OFFSET_WIDTH-1:0] i_rd_slot,
  output l1d_evict_buf_state_t        o_state,
  output logic [L1D_TAG_WIDTH-1:0]    o_tag,
  output logic [L1D_INDEX_WIDTH-1:0]  o_index,
  output logic [L1D_WAY_WIDTH-1:0]    o_way,
  output logic [L1D_OFFSET_WIDTH-1:0] o_start_off,
  output logic [DATA_WIDTH-1:0]       o_rd_data
);

  l1d_evict_buf_state_t r_state;
  l1d_evict_buf_state_t w_state_nxt;
  logic [L1D_TAG_WIDTH-1:0]    r_tag;
  logic [L1D_INDEX_WIDTH-1:0]  r_index;
  logic [L1D_WAY_WIDTH-1:0]    r_way;
  logic [L1D_OFFSET_WIDTH-1:0] r_start_off;
  logic [DATA_WIDTH-1:0]       r_beats [L1D_LINE_BEATS];
  logic                        w_take;

  assign w_take = i_alloc && (r_state == FREE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= FREE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FREE:    if (i_alloc)   w_state_nxt = FILLING;
      FILLING: if (i_wr_done) w_state_nxt = FULL;
      FULL:    if (i_free)    w_state_nxt = FREE;
      default:                w_state_nxt = FREE;
    endcase
  end

  // Header comes from the first request beat only; later beats of the line leave it alone.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_tag       <= i_tag;
      r_index     <= i_index;
      r_way       <= i_way;
      r_start_off <= i_start_off;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_beats[i_wr_slot] <= i_wr_data;
  end

  assign o_state     = r_state;
  assign o_tag       = r_tag;
  assign o_index     = r_index;
  assign o_way       = r_way;
  assign o_start_off = r_start_off;
  assign o_rd_data   = r_beats[i_rd_slot];

endmodule

// File: rtl/l1d_evict_wb_buf.sv
// Evict write-back buffer: collects victim lines from the data RAM into a
// ring of line buffers and streams completed lines to the write-back channel.
module l1d_evict_wb_buf
  import l1d_evict_wb_buf_pkg::*;
#(
  parameter int DEPTH      = L1D_EVICT_BUF_DEPTH,
  parameter int DATA_WIDTH = L1D_DATA_WIDTH,
  parameter int RD_LAT     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        evict_req_vld,
  input  pack_l1d_mshr_evict_req_pld  evict_req_pld,
  output logic                        downstream_evict_rdy,
  input  logic                        ram_rd_vld,
  input  logic [DATA_WIDTH-1:0]       ram_rd_data,
  output logic                        wb_vld,
  input  logic                        wb_rdy,
  output logic [L1D_TAG_WIDTH-1:0]    wb_tag,
  output logic [L1D_INDEX_WIDTH-1:0]  wb_index,
  output logic [L1D_OFFSET_WIDTH-1:0] wb_offset,
  output logic [DATA_WIDTH-1:0]       wb_data,
  output logic                        wb_last
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]               r_req_ptr, r_fill_ptr, r_drain_ptr;
  logic [L1D_OFFSET_WIDTH-1:0] r_req_cnt, r_fill_cnt, r_drain_cnt;

  l1d_evict_buf_state_t        w_state     [DEPTH];
  logic [L1D_TAG_WIDTH-1:0]    w_tag       [DEPTH];
  logic [L1D_INDEX_WIDTH-1:0]  w_index     [DEPTH];
  logic [L1D_WAY_WIDTH-1:0]    w_way       [DEPTH];
  logic [L1D_OFFSET_WIDTH-1:0] w_start_off [DEPTH];
  logic [DATA_WIDTH-1:0]       w_rd_data   [DEPTH];

  logic w_req_acc, w_alloc, w_fill_done, w_wb_fire, w_wb_done;

  // Requests run ahead of returning data, so allocation follows its own pointer;
  // a new line is only admitted once the entry it will occupy is already free.
  assign downstream_evict_rdy = !rst && ((r_req_cnt != '0) || (w_state[r_req_ptr] == FREE));

  assign w_req_acc   = evict_req_vld && downstream_evict_rdy;
  assign w_alloc     = w_req_acc && (r_req_cnt == '0);
  assign w_fill_done = ram_rd_vld && (&r_fill_cnt);
  assign w_wb_fire   = wb_vld && wb_rdy;
  assign w_wb_done   = w_wb_fire && wb_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ptr   <= '0;
      r_req_cnt   <= '0;
      r_fill_ptr  <= '0;
      r_fill_cnt  <= '0;
      r_drain_ptr <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_req_acc) begin
        if (evict_req_pld.rd_last) begin
          r_req_cnt <= '0;
          r_req_ptr <= r_req_ptr + 1'b1;
        end else begin
          r_req_cnt <= r_req_cnt + 1'b1;
        end
      end
      if (ram_rd_vld) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
        if (w_fill_done) r_fill_ptr <= r_fill_ptr + 1'b1;
      end
      if (w_wb_fire) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
        if (w_wb_done) r_drain_ptr <= r_drain_ptr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    l1d_evict_line_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
      .clk         (clk),
      .rst         (rst),
      .i_alloc     (w_alloc && (r_req_ptr == PW'(g))),
      .i_tag       (evict_req_pld.tag),
      .i_index     (evict_req_pld.index),
      .i_way       (evict_req_pld.way),
      .i_start_off (evict_req_pld.offset),
      .i_wr_en     (ram_rd_vld && (r_fill_ptr == PW'(g))),
      .i_wr_slot   (r_fill_cnt),
      .i_wr_data   (ram_rd_data),
      .i_wr_done   (w_fill_done && (r_fill_ptr == PW'(g))),
      .i_free      (w_wb_done && (r_drain_ptr == PW'(g))),
      .i_rd_slot   (r_drain_cnt),
      .o_state     (w_state[g]),
      .o_tag       (w_tag[g]),
      .o_index     (w_index[g]),
      .o_way       (w_way[g]),
      .o_start_off (w_start_off[g]),
      .o_rd_data   (w_rd_data[g])
    );
  end

  assign wb_vld    = (w_state[r_drain_ptr] == FULL);
  assign wb_tag    = w_tag[r_drain_ptr];
  assign wb_index  = w_index[r_drain_ptr];
  assign wb_offset = w_start_off[r_drain_ptr] + r_drain_cnt;
  assign wb_data   = w_rd_data[r_drain_ptr];
  assign wb_last   = &r_drain_cnt;

  a_rd_into_free: assert property (@(posedge clk) disable iff (rst)
    ram_rd_vld |-> (w_state[r_fill_ptr] != FREE));
  a_req_without_rdy: assert property (@(posedge clk) disable iff (rst)
    evict_req_vld |-> downstream_evict_rdy);
  a_line_too_long: assert property (@(posedge clk) disable iff (rst)
    (evict_req_vld && (&r_req_cnt)) |-> evict_req_pld.rd_last);
  a_rd_latency: assert property (@(posedge clk) disable iff (rst)
    ram_rd_vld |-> $past(w_req_acc, RD_LAT));
  a_same_victim: assert property (@(posedge clk) disable iff (rst)
    (w_req_acc && (r_req_cnt != '0)) |->
      (evict_req_pld.way == w_way[r_req_ptr]) && (evict_req_pld.tag == w_tag[r_req_ptr]));

endmodule

// File: tb/tb_l1d_evict_wb_buf.sv
// Directed bench for l1d_evict_wb_buf: a 2-cycle RAM model feeds data in
// request order and a scoreboard queue holds every write-back beat expected.
module tb_l1d_evict_wb_buf;
  import l1d_evict_wb_buf_pkg::*;

  localparam int DW = L1D_DATA_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic                        evict_req_vld;
  pack_l1d_mshr_evict_req_pld  evict_req_pld;
  logic                        downstream_evict_rdy;
  logic                        ram_rd_vld;
  logic [DW-1:0]               ram_rd_data;
  logic                        wb_vld;
  logic                        wb_rdy;
  logic [L1D_TAG_WIDTH-1:0]    wb_tag;
  logic [L1D_INDEX_WIDTH-1:0]  wb_index;
  logic [L1D_OFFSET_WIDTH-1:0] wb_offset;
  logic [DW-1:0]               wb_data;
  logic                        wb_last;

  l1d_evict_wb_buf #(.DEPTH(2), .DATA_WIDTH(DW), .RD_LAT(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .evict_req_vld        (evict_req_vld),
    .evict_req_pld        (evict_req_pld),
    .downstream_evict_rdy (downstream_evict_rdy),
    .ram_rd_vld           (ram_rd_vld),
    .ram_rd_data          (ram_rd_data),
    .wb_vld               (wb_vld),
    .wb_rdy               (wb_rdy),
    .wb_tag               (wb_tag),
    .wb_index             (wb_index),
    .wb_offset            (wb_offset),
    .wb_data              (wb_data),
    .wb_last              (wb_last)
  );

  pack_l1d_mshr_evict_req_pld reqQ [$];
  logic [DW:0]                dataQ [$];
  pack_l1d_evict_wb_pld       expQ [$];

  int   errors = 0;
  int   checks = 0;
  int   fullLines = 0;
  int   linesDrained = 0;
  int   dataBeatsSeen = 0;
  logic pipeVld = 1'b0;
  logic [DW:0] pipeBeat = '0;
  logic ramLastCur = 1'b0;
  bit   randMode = 1'b0;
  logic fixedRdy = 1'b1;

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [L1D_TAG_WIDTH-1:0] tag, input logic [L1D_INDEX_WIDTH-1:0] idx,
                               input logic [L1D_WAY_WIDTH-1:0] way, input logic [L1D_OFFSET_WIDTH-1:0] start,
                               input logic [DW-1:0] base);
    pack_l1d_mshr_evict_req_pld r;
    pack_l1d_evict_wb_pld e;
    for (int k = 0; k < L1D_LINE_BEATS; k++) begin
      r.tag     = tag;
      r.way     = way;
      r.index   = idx;
      r.offset  = start + L1D_OFFSET_WIDTH'(k);
      r.rd_last = (k == L1D_LINE_BEATS - 1);
      reqQ.push_back(r);
      dataQ.push_back({r.rd_last, base + DW'(k)});
      e.tag    = tag;
      e.index  = idx;
      e.offset = r.offset;
      e.data   = base + DW'(k);
      e.last   = r.rd_last;
      expQ.push_back(e);
    end
  endtask

  task automatic setWbRdy(input logic v);
    fixedRdy = v;
    wb_rdy   = v;
  endtask

  // One clock: score the write-back beat seen before the edge, then advance the RAM model and drivers.
  task automatic tick();
    logic acc, fillLastNow, wbFire;
    pack_l1d_evict_wb_pld popped;
    acc         = evict_req_vld && downstream_evict_rdy;
    fillLastNow = ram_rd_vld && ramLastCur;
    wbFire      = wb_vld && wb_rdy;
    if (ram_rd_vld) dataBeatsSeen++;
    if (wb_vld) begin
      if (expQ.size() == 0) begin
        checkOutput("wb_spurious", wb_vld, 0);
      end else begin
        checkOutput("wb_tag", wb_tag, expQ[0].tag);
        checkOutput("wb_index", wb_index, expQ[0].index);
        checkOutput("wb_offset", wb_offset, expQ[0].offset);
        checkOutput("wb_data", wb_data, expQ[0].data);
        checkOutput("wb_last", wb_last, expQ[0].last);
      end
    end
    @(posedge clk);
    #1;
    ram_rd_vld = pipeVld;
    {ramLastCur, ram_rd_data} = pipeBeat;
    pipeVld = 1'b0;
    if (acc) begin
      void'(reqQ.pop_front());
      pipeVld  = 1'b1;
      pipeBeat = dataQ.pop_front();
    end
    if (fillLastNow) fullLines++;
    if (wbFire && expQ.size() > 0) begin
      popped = expQ.pop_front();
      if (popped.last) begin
        fullLines--;
        linesDrained++;
      end
    end
    checkOutput("wb_vld", wb_vld, fullLines > 0);
    if (reqQ.size() > 0 && downstream_evict_rdy) begin
      evict_req_vld = 1'b1;
      evict_req_pld = reqQ[0];
    end else begin
      evict_req_vld = 1'b0;
    end
    wb_rdy = randMode ? 1'($urandom_range(0, 1)) : fixedRdy;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((reqQ.size() > 0 || pipeVld || ram_rd_vld || expQ.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    evict_req_vld = 1'b0;
    ram_rd_vld = 1'b0;
    ramLastCur = 1'b0;
    pipeVld = 1'b0;
    reqQ.delete();
    dataQ.delete();
    expQ.delete();
    fullLines = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      checkOutput("rdy_in_reset", downstream_evict_rdy, 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("rdy_after_reset", downstream_evict_rdy, 1);
    checkOutput("wb_vld_after_reset", wb_vld, 0);
    checkOutput("wb_last_after_reset", wb_last, 0);
  endtask

  initial begin
    int target, n, d;
    rst = 1'b1;
    evict_req_vld = 1'b0;
    evict_req_pld = '0;
    ram_rd_vld = 1'b0;
    ram_rd_data = '0;
    wb_rdy = 1'b1;
    applyReset(3);

    setWbRdy(1'b1);
    applyStimulus(20'h12345, 6'h05, 2'd1, 2'd0, 64'hA0);
    waitIdle("t1_single_line", 60);

    applyStimulus(20'h0BEEF, 6'h2A, 2'd2, 2'd2, 64'hB0);
    waitIdle("t2_wrap", 60);

    setWbRdy(1'b0);
    applyStimulus(20'h00AAA, 6'h11, 2'd0, 2'd1, 64'h1000);
    applyStimulus(20'h00BBB, 6'h22, 2'd3, 2'd3, 64'h2000);
    n = 0;
    while (fullLines < 2 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("t3_rdy_when_full", downstream_evict_rdy, 0);
    repeat (3) tick();
    checkOutput("t3_rdy_still_full", downstream_evict_rdy, 0);
    setWbRdy(1'b1);
    d = linesDrained;
    n = 0;
    while (linesDrained == d && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t3_rdy_after_free", downstream_evict_rdy, 1);
    waitIdle("t3_backpressure", 60);

    randMode = 1'b1;
    applyStimulus(20'h11111, 6'h01, 2'd0, 2'd1, 64'h10);
    applyStimulus(20'h22222, 6'h02, 2'd1, 2'd3, 64'h20);
    applyStimulus(20'h33333, 6'h03, 2'd2, 2'd0, 64'h30);
    applyStimulus(20'h44444, 6'h04, 2'd3, 2'd2, 64'h40);
    waitIdle("t4_concurrent", 400);
    randMode = 1'b0;
    setWbRdy(1'b1);

    applyStimulus(20'h0DEAD, 6'h3F, 2'd1, 2'd0, 64'hD0);
    target = dataBeatsSeen + 2;
    n = 0;
    while (dataBeatsSeen < target && n < 20) begin
      tick();
      n++;
    end
    applyReset(2);
    repeat (4) tick();
    applyStimulus(20'h0CAFE, 6'h0C, 2'd2, 2'd0, 64'hC0);
    waitIdle("t5_after_reset", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
